// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding and fetch address constants.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/seq_pc_reg.sv
// Program counter register with load enable.
// Asynchronously returns to RESET_PC while reset is low.
module seq_pc_reg
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: issues word fetches, holds the result
// for decode, and discards responses overtaken by a redirect.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        dec_ready,
    output logic [31:0] fetch_cnt
);

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pc_load;

    logic [31:0] tgt_q;
    logic [31:0] tgt_in;
    logic        tgt_load;

    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        capture;

    logic [31:0] cnt_q;
    logic        cnt_inc;

    assign tgt_in = word_align(redirect_target);

    seq_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect always wins over the current fetch stream; an
    // outstanding request is then allowed to finish and is dropped.
    always_comb begin
        state_d  = state_q;
        pc_load  = 1'b0;
        pc_d     = pc_q;
        tgt_load = 1'b0;
        capture  = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        pc_load = 1'b1;
                        pc_d    = tgt_in;
                    end else begin
                        tgt_load = 1'b1;
                        state_d  = ST_DROP;
                    end
                end else if (imem_ack) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                tgt_load = redirect_valid;
                if (imem_ack) begin
                    pc_load = 1'b1;
                    pc_d    = redirect_valid ? tgt_in : tgt_q;
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                cnt_inc = dec_ready;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_d    = tgt_in;
                    state_d = ST_FETCH;
                end else if (dec_ready) begin
                    pc_load = 1'b1;
                    pc_d    = instr_pc_q + INSTR_BYTES;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q <= 32'h0;
        end else if (tgt_load) begin
            tgt_q <= tgt_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else if (capture) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 32'h0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign imem_req    = (state_q != ST_HOLD);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios followed by
// random redirect/ack/ready traffic against a transaction-level model.
module tb_fetch_seq;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_ready;
    logic [31:0] fetch_cnt;

    int n_chk;
    int n_err;

    // Reference model: what the fetcher is asking for, what it holds,
    // and whether the in-flight response is already stale.
    logic [31:0] m_pc;
    logic        m_has;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_cnt;
    logic        m_stale;
    logic [31:0] m_tgt;

    fetch_seq #(
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .dec_ready       (dec_ready),
        .fetch_cnt       (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0000;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_has   = 1'b0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_cnt   = 32'h0;
        m_stale = 1'b0;
        m_tgt   = 32'h0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".req"},   {31'h0, imem_req},    {31'h0, !m_has});
        check({tag, ".addr"},  imem_addr,            m_pc);
        check({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, m_has});
        check({tag, ".instr"}, instr,                m_instr);
        check({tag, ".ipc"},   instr_pc,             m_ipc);
        check({tag, ".cnt"},   fetch_cnt,            m_cnt);
    endtask

    // Called at a negedge: check, drive one cycle of inputs, advance
    // the model across the rising edge, return at the next negedge.
    task automatic cyc(input string tag, input logic rv,
                       input logic [31:0] rt, input logic ack,
                       input logic dr);
        logic [31:0] t;
        check_outputs(tag);
        redirect_valid  = rv;
        redirect_target = rt;
        imem_ack        = ack;
        dec_ready       = dr;
        imem_rdata      = ack ? mem_word(m_pc) : $urandom;
        @(posedge clk);
        t = {rt[31:2], 2'b00};
        if (m_has) begin
            if (dr) m_cnt = m_cnt + 1;
            if (rv) begin
                m_pc  = t;
                m_has = 1'b0;
            end else if (dr) begin
                m_pc  = m_ipc + 4;
                m_has = 1'b0;
            end
        end else if (ack) begin
            if (rv) begin
                m_pc    = t;
                m_stale = 1'b0;
            end else if (m_stale) begin
                m_pc    = m_tgt;
                m_stale = 1'b0;
            end else begin
                m_has   = 1'b1;
                m_instr = mem_word(m_pc);
                m_ipc   = m_pc;
            end
        end else if (rv) begin
            m_stale = 1'b1;
            m_tgt   = t;
        end
        @(negedge clk);
    endtask

    initial begin
        n_chk           = 0;
        n_err           = 0;
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        dec_ready       = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst.req",  {31'h0, imem_req},    32'h1);
        check("rst.addr", imem_addr,            32'h0000_3000);
        check("rst.val",  {31'h0, instr_valid}, 32'h0);
        check("rst.cnt",  fetch_cnt,            32'h0);

        // Straight-line fetch, one instruction per two cycles
        repeat (6) cyc("seq", 1'b0, 32'h0, 1'b1, 1'b1);
        check("seq.cnt3", fetch_cnt, 32'd3);
        check("seq.addr", imem_addr, 32'h0000_300C);

        // Redirect with late ack: stale data dropped
        cyc("drop", 1'b1, 32'h0000_3043, 1'b0, 1'b1);
        cyc("drop", 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("drop", 1'b0, 32'h0, 1'b1, 1'b1);
        check("drop.addr", imem_addr, 32'h0000_3040);
        check("drop.val", {31'h0, instr_valid}, 32'h0);

        // Redirect and ack together
        cyc("rdack", 1'b1, 32'h0000_5008, 1'b1, 1'b1);
        check("rdack.addr", imem_addr, 32'h0000_5008);
        check("rdack.val", {31'h0, instr_valid}, 32'h0);

        // Decode stall in HOLD
        cyc("stall", 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (5) cyc("stall", 1'b0, 32'h0, 1'b0, 1'b0);
        check("stall.ipc", instr_pc, 32'h0000_5008);
        check("stall.req", {31'h0, imem_req}, 32'h0);
        cyc("stall", 1'b0, 32'h0, 1'b0, 1'b1);
        check("stall.next", imem_addr, 32'h0000_500C);

        // Two redirects while dropping: last wins
        cyc("two", 1'b1, 32'h0000_4000, 1'b0, 1'b1);
        cyc("two", 1'b1, 32'h0000_5000, 1'b0, 1'b1);
        cyc("two", 1'b0, 32'h0, 1'b1, 1'b1);
        check("two.addr", imem_addr, 32'h0000_5000);

        // Address wrap at the top of memory
        cyc("wrap", 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        check("wrap.top", imem_addr, 32'hFFFF_FFFC);
        cyc("wrap", 1'b0, 32'h0, 1'b1, 1'b1);
        cyc("wrap", 1'b0, 32'h0, 1'b0, 1'b1);
        check("wrap.zero", imem_addr, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [31:0] rt;
            rv = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                             : $urandom;
            cyc("rnd", rv, rt, $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) != 0);
        end

        // Reset asserted while a request is outstanding
        cyc("pre", 1'b1, 32'h0000_7000, 1'b1, 1'b1);
        cyc("pre", 1'b0, 32'h0, 1'b1, 1'b1);
        cyc("pre", 1'b0, 32'h0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst.req",   {31'h0, imem_req},    32'h1);
        check("arst.addr",  imem_addr,            32'h0000_3000);
        check("arst.val",   {31'h0, instr_valid}, 32'h0);
        check("arst.instr", instr,                32'h0);
        check("arst.ipc",   instr_pc,             32'h0);
        check("arst.cnt",   fetch_cnt,            32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            cyc("post", $urandom_range(0, 9) == 0, $urandom,
                $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0);
        end
        check_outputs("end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port redirect_valid, input, 1, next-PC override from branch/jump/jr resolution.
REQ-005 SHALL have port redirect_target, input, 32, override target; bits [1:0] ignored and treated as 00.
REQ-006 SHALL have port imem_req, output, 1, instruction memory request.
REQ-007 SHALL have port imem_addr, output, 32, request address, word aligned.
REQ-008 SHALL have port imem_ack, input, 1, memory accepted the request and imem_rdata is valid this cycle.
REQ-009 SHALL have port imem_rdata, input, 32, returned instruction word.
REQ-010 SHALL have port instr_valid, output, 1, instr/instr_pc hold a valid fetched instruction.
REQ-011 SHALL have port instr, output, 32, fetched instruction.
REQ-012 SHALL have port instr_pc, output, 32, address of instr.
REQ-013 SHALL have port dec_ready, input, 1, decode consumes instr this cycle when instr_valid is 1.
REQ-014 SHALL have port fetch_cnt, output, 32, count of instructions handed to decode.

Function
REQ-015 SHALL implement FSM states FETCH (request outstanding), HOLD (instruction held for decode) and DROP (outstanding request to be discarded).
REQ-016 In FETCH and DROP, imem_req SHALL be 1; in HOLD it SHALL be 0.
REQ-017 While imem_req is 1 and imem_ack is 0, imem_addr SHALL remain stable.
REQ-018 FETCH with ack and no redirect: capture imem_rdata and pc into instr/instr_pc; go to HOLD; instr_valid is 1 from the next cycle.
REQ-019 FETCH with redirect_valid, ack or not: latch the aligned target; go to DROP if there is no ack; go to FETCH with pc equal to the target if ack is present; discard the response in both cases.
REQ-020 DROP: a further redirect_valid SHALL overwrite the latched target (last wins); on ack, discard the data, set pc to the latched target, and go to FETCH.
REQ-021 HOLD with dec_ready and no redirect: set pc to instr_pc+4 (mod 2^32, wraps 0xFFFF_FFFC to 0), increment fetch_cnt, and go to FETCH.
REQ-022 HOLD with redirect_valid: set pc to the target and go to FETCH; fetch_cnt increments only if dec_ready is also 1.
REQ-023 HOLD with dec_ready=0: instr, instr_pc and instr_valid SHALL be held unchanged.
REQ-024 instr_valid SHALL be 1 only in HOLD.
REQ-025 fetch_cnt SHALL wrap from 0xFFFF_FFFF to 0.
REQ-026 imem_addr SHALL equal the pc register.
REQ-027 Steady-state throughput with a 1-cycle ack and dec_ready=1 SHALL be one instruction per 2 cycles.

Reset
REQ-028 On reset low, the block SHALL asynchronously set state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0 and fetch_cnt=0; imem_req SHALL read 1 from the first cycle after release.
REQ-029 If reset is asserted while a request is outstanding, the block SHALL abandon the request; the memory side is reset by the same signal.

Structure
REQ-030 A shared package SHALL hold the state encoding (FETCH=2'd0, HOLD=2'd1, DROP=2'd2), RESET_PC_DEFAULT and INSTR_BYTES=4.
REQ-031 The block SHALL instantiate one sub-module, seq_pc_reg: a 32-bit register with asynchronous active-low reset to RESET_PC and a load enable.
REQ-032 Next-target selection SHALL stay inside fetch_seq; the existing next-PC logic supplies redirect_target.

Verification
REQ-033 Release reset, ack every cycle, dec_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; instr_pc matches; fetch_cnt=3 after the third consume.
REQ-034 Redirect to 0x3043 in FETCH with no ack, ack 2 cycles later -> state DROP, discarded data never reaches instr_valid, next imem_addr=0x3040.
REQ-035 Redirect and ack in the same FETCH cycle -> no instr_valid; next imem_addr equals the target.
REQ-036 Hold dec_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, fetch_cnt unchanged; then dec_ready=1 -> advance to pc+4.
REQ-037 Two redirects in DROP (0x4000 then 0x5000) -> fetch resumes at 0x5000.
REQ-038 Set pc=0xFFFF_FFFC by redirect, then consume -> next imem_addr=0x0000_0000; separately, assert reset mid-FETCH -> all outputs at reset values immediately.
